note_sequencer: RTL and testbench
=================================

// Module: note_sequencer
// PURPOSE
//  Plays a programmable melody by driving the inputFrequency port of the sine signal generator.
//  Holds a small note table (frequency + duration per entry) and steps through it at CLK_32KHz.
//  Changes note only when the generator reports indexZero (waveform at table index 0), so note changes are click-free.
//  Sits between the front-panel/mode control logic and the signal generator feeding the audio PWM/DAC path.
// PARAMETERS
//  NUM_NOTES       16    table depth; address width AW = $clog2(NUM_NOTES)
//  TICKS_PER_UNIT  3200  CLK_32KHz cycles per duration unit (3200 = 100 ms)
//  ZERO_TIMEOUT    400   max cycles spent in WAIT_ZERO before forcing advance (> 320-cycle period at 100 Hz)
// PORTS
//  CLK_32KHz        in   1    sole clock, 32 kHz
//  reset            in   1    synchronous, active-high
//  start            in   1    begin playback at entry 0; ignored unless IDLE or DONE
//  stop             in   1    abort playback; wins over start in the same cycle
//  loop_en          in   1    1: wrap to entry 0 at end of song; 0: go to DONE
//  wr_en            in   1    table write strobe
//  wr_addr          in   AW   table write address; write ignored if >= NUM_NOTES
//  wr_freq          in   14   note frequency in Hz; 0 = rest
//  wr_dur           in   8    duration in units; 0 = end-of-song marker
//  indexZero        in   1    from signal generator: current sample index is 0
//  outputFrequency  out  14   to generator inputFrequency; registered
//  gate             out  1    1 while a non-rest note is sounding
//  busy             out  1    1 in PLAY or WAIT_ZERO
//  done             out  1    one-cycle pulse on entry to DONE
//  noteIndex        out  AW   entry currently playing
// BEHAVIOUR
//  - Reset: state IDLE; outputFrequency=0, gate=0, busy=0, done=0, noteIndex=0; counters cleared.
//    Table contents are NOT cleared by reset.
//  - Table: register array written on wr_en at any time, with 1-cycle write latency. The current note is latched at load.
//    A write to the playing entry takes effect only on its next load.
//  - Frequency clamp at load: 1..99 -> 100; >8000 -> 8000; 0 stays 0 (rest).
//  - States: IDLE, PLAY, WAIT_ZERO, DONE.
//  - IDLE/DONE + start (no stop) -> load entry 0 at the next edge:
//    - dur==0: DONE, done pulse, outputFrequency=0.
//    - otherwise: PLAY, outputFrequency=clamped freq, gate=(freq!=0), busy=1.
//  - Load: sets noteIndex, clears tick counter (0..TICKS_PER_UNIT-1), sets unit counter to dur.
//  - PLAY: tick counter increments each cycle; on wrap the unit counter decrements.
//    The note occupies exactly dur*TICKS_PER_UNIT cycles in PLAY.
//    On the last PLAY cycle: rest -> advance directly; tone -> WAIT_ZERO.
//  - WAIT_ZERO: outputFrequency held. Advance in the first cycle where indexZero==1 (including the first WAIT_ZERO cycle),
//    or after ZERO_TIMEOUT cycles.
//  - Advance: next = noteIndex+1.
//    - End of song when next==NUM_NOTES or entry[next].dur==0:
//      - loop_en=1: load entry 0. If entry 0 has dur==0 -> DONE.
//      - loop_en=0: DONE, done=1 for one cycle, outputFrequency=0, gate=0, busy=0.
//    - Otherwise: load entry next.
//    - loop_en is sampled at the advance cycle.
//  - stop in any state -> IDLE at the next edge; outputs return to their reset values, with no done pulse.
//    Table is untouched.
//  - start while busy is ignored (no restart). DONE persists until start or stop.
//  - reset asserted mid-note takes priority over all inputs.
// TESTING
//  1. Load {440 Hz,2},{0,1},{880 Hz,1},{x,0}, then pulse start.
//     -> outputFrequency=440 and gate=1 for 6400 cycles, then held until indexZero.
//     -> then freq 0 and gate 0 for exactly 3200 cycles; 880 for 3200 cycles.
//     -> then WAIT_ZERO; done pulses once and busy falls.
//  2. indexZero held 0 during WAIT_ZERO -> advance occurs exactly ZERO_TIMEOUT cycles after entry.
//     indexZero=1 on the first WAIT_ZERO cycle -> advance in that cycle.
//  3. loop_en=1 with a 3-note song -> noteIndex sequence 0,1,2,0,1,..., with no done pulse.
//     Clear loop_en during note 2 -> DONE after note 2.
//  4. stop asserted at tick 1000 of note 0, with start also high in that cycle.
//     -> IDLE next edge; all outputs 0; done stays 0.
//  5. Write freq 50 and freq 12000 -> outputFrequency 100 and 8000.
//     Write wr_addr >= NUM_NOTES -> table unchanged.
//     Write the playing entry -> current note unchanged.
//  6. Entry 0 dur==0, then start -> DONE next edge with done=1 for one cycle, gate never high.
//     reset mid-PLAY -> all outputs 0 at the next edge.

Source files
------------

// File: rtl/note_sequencer_if.sv
// Control, table-write and generator-facing signals of the note sequencer.
// The master side is the front-panel/mode logic; the slave side is the sequencer.
interface note_sequencer_if #(
  parameter int AW = 4
);
  logic          start;
  logic          stop;
  logic          loop_en;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [13:0]   wr_freq;
  logic [7:0]    wr_dur;
  logic          indexZero;
  logic [13:0]   outputFrequency;
  logic          gate;
  logic          busy;
  logic          done;
  logic [AW-1:0] noteIndex;

  modport master (
    output start, stop, loop_en, wr_en, wr_addr, wr_freq, wr_dur, indexZero,
    input  outputFrequency, gate, busy, done, noteIndex
  );

  modport slave (
    input  start, stop, loop_en, wr_en, wr_addr, wr_freq, wr_dur, indexZero,
    output outputFrequency, gate, busy, done, noteIndex
  );
endinterface

// File: rtl/note_sequencer.sv
// Steps through a frequency/duration note table and drives the sine generator,
// changing note only at a waveform zero index so transitions are click-free.
module note_sequencer #(
  parameter int NUM_NOTES      = 16,
  parameter int TICKS_PER_UNIT = 3200,
  parameter int ZERO_TIMEOUT   = 400
) (
  input logic             CLK_32KHz,
  input logic             reset,
  note_sequencer_if.slave bus
);
  localparam int AW = $clog2(NUM_NOTES);
  localparam int TW = $clog2(TICKS_PER_UNIT);
  localparam int ZW = $clog2(ZERO_TIMEOUT);
  localparam int TL = TICKS_PER_UNIT - 1;
  localparam int ZL = ZERO_TIMEOUT - 1;
  localparam logic [AW:0]   NOTE_END  = NUM_NOTES[AW:0];
  localparam logic [TW-1:0] TICK_LAST = TL[TW-1:0];
  localparam logic [ZW-1:0] WAIT_LAST = ZL[ZW-1:0];

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_PLAY = 2'd1,
    S_WAIT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  function automatic logic [13:0] clamp_freq(input logic [13:0] f);
    if (f == 14'd0) begin
      clamp_freq = 14'd0;
    end else if (f < 14'd100) begin
      clamp_freq = 14'd100;
    end else if (f > 14'd8000) begin
      clamp_freq = 14'd8000;
    end else begin
      clamp_freq = f;
    end
  endfunction

  logic [13:0]   freq_mem_r [NUM_NOTES];
  logic [7:0]    dur_mem_r  [NUM_NOTES];
  state_t        state_r, state_s, stay_s;
  logic [13:0]   freq_r, freq_s;
  logic          gate_r, gate_s, busy_r, busy_s, done_r, done_s;
  logic [AW-1:0] idx_r, idx_s, tgt_s, adv_tgt_s;
  logic [TW-1:0] tick_r, tick_s;
  logic [7:0]    unit_r, unit_s;
  logic [ZW-1:0] wz_r, wz_s;
  logic [AW:0]   next_idx_s;
  logic          go_s, tgt_ok_s, load_s, adv_ok_s;
  logic          last_play_s, zero_hit_s, song_end_s;

  assign next_idx_s  = {1'b0, idx_r} + {{AW{1'b0}}, 1'b1};
  assign song_end_s  = (next_idx_s >= NOTE_END) || (dur_mem_r[next_idx_s[AW-1:0]] == 8'd0);
  assign adv_ok_s    = !song_end_s || bus.loop_en;
  assign adv_tgt_s   = song_end_s ? {AW{1'b0}} : next_idx_s[AW-1:0];
  assign last_play_s = (tick_r == TICK_LAST) && (unit_r == 8'd1);
  assign zero_hit_s  = bus.indexZero || (wz_r == WAIT_LAST);

  // Note table: writable at any time, deliberately untouched by reset
  always_ff @(posedge CLK_32KHz) begin
    if (bus.wr_en && ({1'b0, bus.wr_addr} < NOTE_END)) begin
      freq_mem_r[bus.wr_addr] <= bus.wr_freq;
      dur_mem_r[bus.wr_addr]  <= bus.wr_dur;
    end
  end

  // State register
  always_ff @(posedge CLK_32KHz) begin
    if (reset) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next state: start/advance pick a target entry; an empty target ends the song
  always_comb begin
    stay_s   = state_r;
    go_s     = 1'b0;
    tgt_ok_s = 1'b0;
    tgt_s    = {AW{1'b0}};
    case (state_r)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          go_s     = 1'b1;
          tgt_ok_s = 1'b1;
        end else begin
          stay_s = state_r;
        end
      end
      S_PLAY: begin
        if (last_play_s && (freq_r == 14'd0)) begin
          go_s     = 1'b1;
          tgt_ok_s = adv_ok_s;
          tgt_s    = adv_tgt_s;
        end else if (last_play_s) begin
          stay_s = S_WAIT;
        end else begin
          stay_s = S_PLAY;
        end
      end
      S_WAIT: begin
        if (zero_hit_s) begin
          go_s     = 1'b1;
          tgt_ok_s = adv_ok_s;
          tgt_s    = adv_tgt_s;
        end else begin
          stay_s = S_WAIT;
        end
      end
      default: begin
        stay_s = S_IDLE;
      end
    endcase
    load_s = go_s && tgt_ok_s && (dur_mem_r[tgt_s] != 8'd0) && !bus.stop;
    if (bus.stop) begin
      state_s = S_IDLE;
    end else if (go_s) begin
      state_s = load_s ? S_PLAY : S_DONE;
    end else begin
      state_s = stay_s;
    end
  end

  // Output/counter next values, all registered below
  always_comb begin
    freq_s = freq_r;
    gate_s = gate_r;
    busy_s = busy_r;
    done_s = 1'b0;
    idx_s  = idx_r;
    tick_s = tick_r;
    unit_s = unit_r;
    wz_s   = {ZW{1'b0}};
    case (state_s)
      S_PLAY: begin
        if (load_s) begin
          freq_s = clamp_freq(freq_mem_r[tgt_s]);
          gate_s = (freq_mem_r[tgt_s] != 14'd0);
          busy_s = 1'b1;
          idx_s  = tgt_s;
          tick_s = {TW{1'b0}};
          unit_s = dur_mem_r[tgt_s];
        end else if (tick_r == TICK_LAST) begin
          tick_s = {TW{1'b0}};
          unit_s = unit_r - 8'd1;
        end else begin
          tick_s = tick_r + TW'(1);
        end
      end
      S_WAIT: begin
        if (state_r == S_WAIT) begin
          wz_s = wz_r + ZW'(1);
        end else begin
          wz_s = {ZW{1'b0}};
        end
      end
      S_DONE: begin
        freq_s = 14'd0;
        gate_s = 1'b0;
        busy_s = 1'b0;
        done_s = go_s;
        tick_s = {TW{1'b0}};
        unit_s = 8'd0;
      end
      default: begin
        freq_s = 14'd0;
        gate_s = 1'b0;
        busy_s = 1'b0;
        idx_s  = {AW{1'b0}};
        tick_s = {TW{1'b0}};
        unit_s = 8'd0;
      end
    endcase
  end

  // Output and counter registers
  always_ff @(posedge CLK_32KHz) begin
    if (reset) begin
      freq_r <= 14'd0;
      gate_r <= 1'b0;
      busy_r <= 1'b0;
      done_r <= 1'b0;
      idx_r  <= {AW{1'b0}};
      tick_r <= {TW{1'b0}};
      unit_r <= 8'd0;
      wz_r   <= {ZW{1'b0}};
    end else begin
      freq_r <= freq_s;
      gate_r <= gate_s;
      busy_r <= busy_s;
      done_r <= done_s;
      idx_r  <= idx_s;
      tick_r <= tick_s;
      unit_r <= unit_s;
      wz_r   <= wz_s;
    end
  end

  assign bus.outputFrequency = freq_r;
  assign bus.gate            = gate_r;
  assign bus.busy            = busy_r;
  assign bus.done            = done_r;
  assign bus.noteIndex       = idx_r;
endmodule

// File: tb/tb_note_sequencer.sv
// Directed bench for note_sequencer: a 12-entry table so out-of-range writes exist.
module tb_note_sequencer;
  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   passes   = 0;
  int   done_cnt = 0;

  note_sequencer_if #(.AW(4)) bus ();

  note_sequencer #(
    .NUM_NOTES(12),
    .TICKS_PER_UNIT(3200),
    .ZERO_TIMEOUT(400)
  ) dut (
    .CLK_32KHz(clk),
    .reset(reset),
    .bus(bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.done === 1'b1) done_cnt <= done_cnt + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wr(input logic [3:0] a, input logic [13:0] f, input logic [7:0] d);
    bus.wr_en   = 1'b1;
    bus.wr_addr = a;
    bus.wr_freq = f;
    bus.wr_dur  = d;
    @(negedge clk);
    bus.wr_en   = 1'b0;
  endtask

  task automatic start_pulse();
    bus.start = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
  endtask

  // Counts consecutive cycles holding frequency f, bounded by limit
  task automatic run_count(input logic [13:0] f, input int limit, output int n);
    n = 0;
    while ((bus.outputFrequency === f) && (n < limit)) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int dc;
    reset = 1'b1;
    bus.start = 1'b0; bus.stop = 1'b0; bus.loop_en = 1'b0; bus.wr_en = 1'b0;
    bus.wr_addr = 4'd0; bus.wr_freq = 14'd0; bus.wr_dur = 8'd0; bus.indexZero = 1'b1;
    cyc(3);
    check("rst_freq", bus.outputFrequency, 0);
    check("rst_gate", bus.gate, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_done", bus.done, 0);
    check("rst_idx", bus.noteIndex, 0);
    reset = 1'b0;
    cyc(1);

    // 1: tone, rest, tone, end marker
    wr(4'd0, 14'd440, 8'd2); wr(4'd1, 14'd0, 8'd1); wr(4'd2, 14'd880, 8'd1); wr(4'd3, 14'd0, 8'd0);
    start_pulse();
    check("t1_freq0", bus.outputFrequency, 440);
    check("t1_gate0", bus.gate, 1);
    check("t1_busy0", bus.busy, 1);
    check("t1_idx0", bus.noteIndex, 0);
    run_count(14'd440, 7000, n);
    check("t1_len0", n, 6401);
    check("t1_rest_gate", bus.gate, 0);
    check("t1_rest_busy", bus.busy, 1);
    check("t1_rest_idx", bus.noteIndex, 1);
    run_count(14'd0, 4000, n);
    check("t1_rest_len", n, 3200);
    check("t1_freq2", bus.outputFrequency, 880);
    check("t1_idx2", bus.noteIndex, 2);
    run_count(14'd880, 4000, n);
    check("t1_len2", n, 3201);
    check("t1_done", bus.done, 1);
    check("t1_busy_end", bus.busy, 0);
    check("t1_gate_end", bus.gate, 0);
    cyc(1);
    check("t1_done_pulse", bus.done, 0);

    // 2: wait-zero timeout, then immediate indexZero
    wr(4'd0, 14'd1000, 8'd1); wr(4'd1, 14'd0, 8'd0);
    bus.indexZero = 1'b0;
    start_pulse();
    run_count(14'd1000, 5000, n);
    check("t2_timeout_len", n, 3600);
    check("t2_done_a", bus.done, 1);
    bus.indexZero = 1'b1;
    start_pulse();
    run_count(14'd1000, 5000, n);
    check("t2_zero_len", n, 3201);
    check("t2_done_b", bus.done, 1);
    cyc(1);

    // 3: looping three-note song, loop_en cleared during note 2
    wr(4'd0, 14'd200, 8'd1); wr(4'd1, 14'd300, 8'd1); wr(4'd2, 14'd400, 8'd1); wr(4'd3, 14'd0, 8'd0);
    bus.loop_en = 1'b1;
    dc = done_cnt;
    start_pulse();
    for (int k = 0; k < 6; k++) begin
      check("t3_idx", bus.noteIndex, k % 3);
      check("t3_freq", bus.outputFrequency, 200 + 100 * (k % 3));
      if (k == 5) bus.loop_en = 1'b0;
      run_count(bus.outputFrequency, 4000, n);
      check("t3_len", n, 3201);
    end
    check("t3_done", bus.done, 1);
    check("t3_no_early_done", done_cnt - dc, 0);
    cyc(1);
    check("t3_one_done", done_cnt - dc, 1);

    // 4: stop and start together at tick 1000 of note 0
    start_pulse();
    cyc(1000);
    dc = done_cnt;
    bus.stop = 1'b1; bus.start = 1'b1;
    cyc(1);
    bus.stop = 1'b0; bus.start = 1'b0;
    check("t4_freq", bus.outputFrequency, 0);
    check("t4_gate", bus.gate, 0);
    check("t4_busy", bus.busy, 0);
    check("t4_done", bus.done, 0);
    check("t4_idx", bus.noteIndex, 0);
    cyc(2);
    check("t4_idle_busy", bus.busy, 0);
    check("t4_no_done", done_cnt - dc, 0);

    // 5: clamping, rejected writes, write to the playing entry
    wr(4'd0, 14'd50, 8'd1); wr(4'd1, 14'd12000, 8'd1); wr(4'd2, 14'd0, 8'd0);
    start_pulse();
    check("t5_clamp_lo", bus.outputFrequency, 100);
    run_count(14'd100, 4000, n);
    check("t5_len0", n, 3201);
    check("t5_clamp_hi", bus.outputFrequency, 8000);
    wr(4'd1, 14'd2000, 8'd1);
    check("t5_hold_a", bus.outputFrequency, 8000);
    cyc(100);
    wr(4'd12, 14'd7, 8'd9); wr(4'd15, 14'd7, 8'd9);
    check("t5_hold_b", bus.outputFrequency, 8000);
    run_count(14'd8000, 4000, n);
    check("t5_len1_rest", n, 3098);
    check("t5_done", bus.done, 1);
    start_pulse();
    check("t5_entry0_kept", bus.outputFrequency, 100);
    run_count(14'd100, 4000, n);
    check("t5_new_freq", bus.outputFrequency, 2000);
    check("t5_new_idx", bus.noteIndex, 1);
    run_count(14'd2000, 4000, n);
    check("t5_len_new", n, 3201);
    check("t5_done_b", bus.done, 1);
    cyc(1);

    // 6: empty song, then reset mid-note
    wr(4'd0, 14'd500, 8'd0);
    start_pulse();
    check("t6_done", bus.done, 1);
    check("t6_gate", bus.gate, 0);
    check("t6_busy", bus.busy, 0);
    check("t6_freq", bus.outputFrequency, 0);
    cyc(1);
    check("t6_done_pulse", bus.done, 0);
    check("t6_gate_b", bus.gate, 0);
    wr(4'd0, 14'd500, 8'd1);
    start_pulse();
    check("t6_play", bus.outputFrequency, 500);
    cyc(100);
    reset = 1'b1; bus.start = 1'b1;
    cyc(1);
    check("t6_rst_freq", bus.outputFrequency, 0);
    check("t6_rst_gate", bus.gate, 0);
    check("t6_rst_busy", bus.busy, 0);
    check("t6_rst_done", bus.done, 0);
    check("t6_rst_idx", bus.noteIndex, 0);
    reset = 1'b0; bus.start = 1'b0;
    cyc(2);
    check("t6_after_rst", bus.busy, 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
